fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Parametrised successor to the NPC/PC pair: PC register, next-PC mux and return-address stack (RAS) in one block.
//  Adds register-indirect jumps, RAS push/pop for call/return, exception entry (EPC capture) and ERET.
//  Sits at the head of the fetch stage; PC drives IM address, NPC is exposed for debug/branch compare.
//  All addresses are word addresses [ADDR_W-1:2].
// PARAMETERS
//  ADDR_W     32            byte-address width; PC/NPC/EPC/RegTgt are [ADDR_W-1:2]
//  RESET_PC   32'h0000_3000 byte address loaded on reset
//  EXC_VEC    32'h0000_4180 byte address of exception handler
//  RAS_DEPTH  4             return-address stack entries (power of 2, >=2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-low reset
//  PCWr       in   1         PC write enable (0 = stall)
//  NPCOp      in   3         next-PC select, see BEHAVIOUR
//  IMM        in   26        imm16 in [15:0] (branch) / target26 (jump)
//  RegTgt     in   ADDR_W-2  register jump target (JR/JALR), word address
//  Link       in   1         with JUMP/JR: push PC+1 onto RAS
//  Exc        in   1         exception request, highest priority
//  PC         out  ADDR_W-2  current PC (registered)
//  NPC        out  ADDR_W-2  next PC (combinational)
//  EPC        out  ADDR_W-2  saved exception PC (registered)
//  RasEmpty   out  1         RAS holds 0 entries
//  RasFull    out  1         RAS holds RAS_DEPTH entries
//  RasUnder   out  1         comb: RET selected while RAS empty
// BEHAVIOUR
//  - Reset (rst=0 at edge): PC=RESET_PC[ADDR_W-1:2], EPC=0, RAS count=0, ptr=0; rst overrides every other input, mid-op included.
//  - NPCOp: 000 PLUS4 PC+1; 001 BRANCH PC+1+sext(IMM[15:0]); 010 JUMP {PC[ADDR_W-1:28],IMM[25:0]};
//    011 JR RegTgt; 100 RET RAS top (RegTgt if empty); 101 ERET EPC; 110/111 reserved -> PLUS4.
//  - All sums are modulo 2^(ADDR_W-2); no overflow flag.
//  - Exc=1: NPC=EXC_VEC[ADDR_W-1:2]; at the edge PC<=NPC and EPC<=PC, regardless of PCWr; RAS untouched, NPCOp ignored.
//  - Otherwise PC<=NPC only when PCWr=1; PCWr=0 holds PC and blocks all RAS/EPC updates.
//  - Single-cycle latency: NPC valid same cycle, PC changes at next rising edge.
//  - Push (PCWr=1, Link=1, NPCOp in {JUMP,JR}, Exc=0): write PC+1 at ptr, ptr++ (wraps); count saturates at RAS_DEPTH (oldest overwritten).
//  - Link ignored for any other NPCOp.
//  - Pop (PCWr=1, NPCOp=RET, Exc=0, count>0): ptr--, count--. Pop when empty: no state change, target=RegTgt.
//  - Push and pop never coincide (one op per cycle).
//  - RasUnder=(NPCOp==RET)&&count==0 &&!Exc, combinational, independent of PCWr.
// STRUCTURE
//  - Shared include npc_defs.v: NPCOp encodings (NPC_PLUS4..NPC_ERET) for decoder and this block.
//  - Sub-module ras_stack (DEPTH,W): push/pop/top/empty/full, circular pointer + saturating count.
//  - Top: next-PC mux, PC and EPC registers, priority Exc > PCWr.
// TESTING
//  1 rst=0 one edge -> PC=30'h0C00, EPC=0, RasEmpty=1, RasFull=0.
//  2 PLUS4 x3 -> PC=0xC03; BRANCH IMM=16'hFFFF -> PC=0xC03; BRANCH IMM=16'h000F -> PC=0xC13.
//  3 At PC=0xC13, JUMP Link=1 IMM=26'h000FFFF -> PC=0x000FFFF, RasEmpty=0; RET -> PC=0xC14, RasEmpty=1.
//  4 PCWr=0, JUMP Link=1 -> PC and RAS unchanged over 3 edges; RasUnder=1 when NPCOp=RET applied with RAS empty.
//  5 Five linked JUMPs (DEPTH=4) -> RasFull=1; four RETs return the last four PC+1 values in LIFO order.
//    Fifth RET: RasUnder=1, PC=RegTgt.
//  6 Exc=1 with PCWr=0 at PC=0xC05 -> PC=0x1060, EPC=0xC05; ERET -> PC=0xC05; rst=0 mid-sequence -> PC=0xC00, RAS cleared.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Purpose : shared definitions for the fetch PC unit and the instruction
//           decoder. This includes the next-PC select encodings, the bus field
//           widths and a helper that identifies the ops that may link.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  // Width of the next-PC select field and of the immediate field.
  localparam int OP_W  = 3;
  localparam int IMM_W = 26;

  // Next-PC select encodings. Codes 110 and 111 are reserved and behave as PLUS4.
  typedef enum logic [OP_W-1:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JR     = 3'b011,
    NPC_RET    = 3'b100,
    NPC_ERET   = 3'b101
  } npc_op_e;

  // Only JUMP and JR may push a return address. Link is ignored for every other op.
  function automatic logic isLinkOp(input npc_op_e op);
    return (op == NPC_JUMP) || (op == NPC_JR);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
// Purpose : control/address bus between the decoder/pipeline (master) and the
//           fetch PC unit (slave). All addresses are word addresses.
// Signals : i_pcWr     PC write enable (0 = stall)
//           i_npcOp    next-PC select
//           i_imm      imm16 in [15:0] (branch) / target26 (jump)
//           i_regTgt   register jump target (JR/JALR)
//           i_link     push PC+1 onto the RAS with JUMP/JR
//           i_exc      exception request
//           o_pc       registered current PC
//           o_npc      combinational next PC
//           o_epc      saved exception PC
//           o_rasEmpty / o_rasFull  RAS occupancy flags
//           o_rasUnder RET selected while the RAS is empty
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 32
) ();
  import fetch_pc_unit_pkg::*;

  logic              i_pcWr;
  logic [OP_W-1:0]   i_npcOp;
  logic [IMM_W-1:0]  i_imm;
  logic [ADDR_W-3:0] i_regTgt;
  logic              i_link;
  logic              i_exc;
  logic [ADDR_W-3:0] o_pc;
  logic [ADDR_W-3:0] o_npc;
  logic [ADDR_W-3:0] o_epc;
  logic              o_rasEmpty;
  logic              o_rasFull;
  logic              o_rasUnder;

  // Master side drives the control inputs and observes the PC state.
  modport master (
    output i_pcWr, i_npcOp, i_imm, i_regTgt, i_link, i_exc,
    input  o_pc, o_npc, o_epc, o_rasEmpty, o_rasFull, o_rasUnder
  );

  // Slave side is the fetch PC unit itself.
  modport slave (
    input  i_pcWr, i_npcOp, i_imm, i_regTgt, i_link, i_exc,
    output o_pc, o_npc, o_epc, o_rasEmpty, o_rasFull, o_rasUnder
  );

endinterface

// File: rtl/fetch_pc_unit_ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Purpose : return-address stack built as a circular buffer with a saturating
//           occupancy count. When a push arrives on a full stack, the push
//           overwrites the oldest entry. A pop on an empty stack is ignored.
// Ports   : clk, rst (sync, active-low)
//           i_push, i_pushData  write data at ptr, then ptr++
//           i_pop               ptr--, count-- when not empty
//           o_top               most recently pushed live entry
//           o_empty, o_full     occupancy flags
// DEPTH must be a power of two (>=2). This lets the pointer wrap naturally.
// ---------------------------------------------------------------------------
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_pushData,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_topIdx;

  // The pointer always names the next free slot. The top of the stack is
  // therefore the slot just below it, modulo DEPTH.
  assign w_topIdx = r_ptr - PTR_W'(1);
  assign o_top    = r_mem[w_topIdx];
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_W'(DEPTH));

  // Stack state update. A push takes priority, although the caller never asks
  // for a push and a pop in the same cycle. The count stops at DEPTH, so once
  // the pointer wraps, it lands on the oldest entry and the next push replaces it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_ptr] <= i_pushData;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_count != CNT_W'(DEPTH)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Purpose : PC register, next-PC mux, EPC register and return-address stack
//           at the head of the fetch stage. The PC drives the instruction
//           memory address. The NPC is exposed for debug and branch compare.
//           All addresses are word addresses (byte address bits [ADDR_W-1:2]).
// Ports   : clk  rising-edge clock
//           rst  synchronous, active-low reset (overrides everything)
//           bus  fetch_pc_unit_if.slave (see the interface for its fields)
// Priority: Exc > PCWr. An exception loads the vector and captures the EPC,
//           even during a stall. The exception leaves the RAS untouched.
// ADDR_W must be at least 30 so that the JUMP region bits [ADDR_W-1:28] exist.
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int                RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.slave  bus
);

  localparam int AW = ADDR_W - 2;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_epc;
  logic [AW-1:0] w_npc;
  logic [AW-1:0] w_pcPlus1;
  logic [AW-1:0] w_immSext;
  logic [AW-1:0] w_rasTop;
  logic          w_rasEmpty;
  logic          w_rasFull;
  logic          w_push;
  logic          w_pop;
  npc_op_e       w_op;

  assign w_op      = npc_op_e'(bus.i_npcOp);
  assign w_pcPlus1 = r_pc + AW'(1);
  assign w_immSext = {{(AW-16){bus.i_imm[15]}}, bus.i_imm[15:0]};

  // Next-PC selection. An exception overrides the op field. A RET on an empty
  // stack falls back to the register target instead of using stale RAS data.
  // All sums wrap modulo 2^AW.
  always_comb begin
    w_npc = w_pcPlus1;
    if (bus.i_exc) begin
      w_npc = EXC_VEC[ADDR_W-1:2];
    end else begin
      case (w_op)
        NPC_BRANCH: w_npc = w_pcPlus1 + w_immSext;
        NPC_JUMP:   w_npc = {r_pc[AW-1:26], bus.i_imm[25:0]};
        NPC_JR:     w_npc = bus.i_regTgt;
        NPC_RET:    w_npc = w_rasEmpty ? bus.i_regTgt : w_rasTop;
        NPC_ERET:   w_npc = r_epc;
        default:    w_npc = w_pcPlus1;
      endcase
    end
  end

  // The stack only moves on a real, non-exception PC update. A stall freezes
  // the stack along with the PC.
  assign w_push = bus.i_pcWr && !bus.i_exc && bus.i_link && isLinkOp(w_op);
  assign w_pop  = bus.i_pcWr && !bus.i_exc && (w_op == NPC_RET);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (AW)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_pushData (w_pcPlus1),
    .o_top      (w_rasTop),
    .o_empty    (w_rasEmpty),
    .o_full     (w_rasFull)
  );

  // PC and EPC registers. An exception always lands, even with PCWr low. The
  // exception saves the PC of the interrupted instruction. Otherwise, the PC
  // advances only while PCWr is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc  <= RESET_PC[ADDR_W-1:2];
      r_epc <= '0;
    end else if (bus.i_exc) begin
      r_pc  <= w_npc;
      r_epc <= r_pc;
    end else if (bus.i_pcWr) begin
      r_pc  <= w_npc;
    end
  end

  assign bus.o_pc       = r_pc;
  assign bus.o_npc      = w_npc;
  assign bus.o_epc      = r_epc;
  assign bus.o_rasEmpty = w_rasEmpty;
  assign bus.o_rasFull  = w_rasFull;
  assign bus.o_rasUnder = (w_op == NPC_RET) && w_rasEmpty && !bus.i_exc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
// Purpose : directed test of fetch_pc_unit. Each step drives one cycle of
//           control inputs. It then checks the combinational NPC/RasUnder
//           against a behavioural model. The expected post-edge state goes into
//           a scoreboard queue, which is popped and compared after the edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  localparam int ADDR_W = 32;
  localparam int AW     = ADDR_W - 2;
  localparam int DEPTH  = 4;

  localparam logic [AW-1:0] RESET_WORD = 30'h0000_0C00;
  localparam logic [AW-1:0] EXC_WORD   = 30'h0000_1060;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JR     = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_ERET   = 3'b101;

  typedef struct {
    string         tag;
    logic [AW-1:0] pc;
    logic [AW-1:0] epc;
    logic          empty;
    logic          full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  exp_t          sbQueue [$];
  logic [AW-1:0] mPc;
  logic [AW-1:0] mEpc;
  logic [AW-1:0] mRas [$];

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.ADDR_W(ADDR_W)) busIf ();

  fetch_pc_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (32'h0000_3000),
    .EXC_VEC   (32'h0000_4180),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf.slave)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [AW-1:0] observed,
                             input logic [AW-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Behavioural next-PC. The RAS model is a plain queue whose back is the top.
  function automatic logic [AW-1:0] modelNpc(input logic [2:0] op, input logic [25:0] imm,
                                             input logic [AW-1:0] tgt, input logic exc);
    if (exc) return EXC_WORD;
    case (op)
      OP_BRANCH: return mPc + 30'd1 + {{14{imm[15]}}, imm[15:0]};
      OP_JUMP:   return {mPc[29:26], imm};
      OP_JR:     return tgt;
      OP_RET:    return (mRas.size() == 0) ? tgt : mRas[$];
      OP_ERET:   return mEpc;
      default:   return mPc + 30'd1;
    endcase
  endfunction

  // Pop the oldest scoreboard entry and compare it with the registered outputs.
  task automatic popAndCompare();
    exp_t e;
    if (sbQueue.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbQueue.pop_front();
      checkOutput({e.tag, ".pc"},    busIf.o_pc,            e.pc);
      checkOutput({e.tag, ".epc"},   busIf.o_epc,           e.epc);
      checkOutput({e.tag, ".empty"}, AW'(busIf.o_rasEmpty), AW'(e.empty));
      checkOutput({e.tag, ".full"},  AW'(busIf.o_rasFull),  AW'(e.full));
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, and update the
  // model. Then queue the expected post-edge state and compare it after the edge.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [25:0] imm,
                               input logic [AW-1:0] tgt, input logic link, input logic exc,
                               input logic pcWr);
    logic [AW-1:0] npcExp;
    exp_t          e;
    busIf.i_npcOp  = op;
    busIf.i_imm    = imm;
    busIf.i_regTgt = tgt;
    busIf.i_link   = link;
    busIf.i_exc    = exc;
    busIf.i_pcWr   = pcWr;
    #1;
    npcExp = modelNpc(op, imm, tgt, exc);
    checkOutput({tag, ".npc"}, busIf.o_npc, npcExp);
    checkOutput({tag, ".under"}, AW'(busIf.o_rasUnder),
                AW'((op == OP_RET) && (mRas.size() == 0) && !exc));
    if (exc) begin
      mEpc = mPc;
      mPc  = npcExp;
    end else if (pcWr) begin
      if (link && ((op == OP_JUMP) || (op == OP_JR))) begin
        mRas.push_back(mPc + 30'd1);
        if (mRas.size() > DEPTH) void'(mRas.pop_front());
      end else if ((op == OP_RET) && (mRas.size() > 0)) begin
        void'(mRas.pop_back());
      end
      mPc = npcExp;
    end
    e.tag   = tag;
    e.pc    = mPc;
    e.epc   = mEpc;
    e.empty = (mRas.size() == 0);
    e.full  = (mRas.size() == DEPTH);
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare();
  endtask

  // Hold reset for one edge while driving a busy op. Reset must win over the op.
  task automatic doReset(input string tag);
    exp_t e;
    rst            = 1'b0;
    busIf.i_npcOp  = OP_JUMP;
    busIf.i_imm    = 26'h0000_777;
    busIf.i_regTgt = 30'h0000_0123;
    busIf.i_link   = 1'b1;
    busIf.i_exc    = 1'b1;
    busIf.i_pcWr   = 1'b1;
    mPc  = RESET_WORD;
    mEpc = '0;
    mRas.delete();
    e.tag   = tag;
    e.pc    = mPc;
    e.epc   = mEpc;
    e.empty = 1'b1;
    e.full  = 1'b0;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b1;
    busIf.i_exc = 1'b0;
    popAndCompare();
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rst = 1'b0;
    doReset("reset");
    checkOutput("rst.pc",    busIf.o_pc,            30'h0000_0C00);
    checkOutput("rst.epc",   busIf.o_epc,           30'h0);
    checkOutput("rst.empty", AW'(busIf.o_rasEmpty), 30'h1);
    checkOutput("rst.full",  AW'(busIf.o_rasFull),  30'h0);

    for (int i = 0; i < 3; i++) applyStimulus("plus4", OP_PLUS4, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("plus4x3.pc", busIf.o_pc, 30'h0000_0C03);
    applyStimulus("brNeg", OP_BRANCH, 26'h000_FFFF, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("brNeg.pc", busIf.o_pc, 30'h0000_0C03);
    applyStimulus("brPos", OP_BRANCH, 26'h000_000F, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("brPos.pc", busIf.o_pc, 30'h0000_0C13);

    applyStimulus("jal", OP_JUMP, 26'h000_FFFF, 30'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("jal.pc", busIf.o_pc, 30'h000_FFFF);
    checkOutput("jal.empty", AW'(busIf.o_rasEmpty), 30'h0);
    applyStimulus("ret", OP_RET, 26'h0, 30'h0000_03FF, 1'b0, 1'b0, 1'b1);
    checkOutput("ret.pc", busIf.o_pc, 30'h0000_0C14);
    checkOutput("ret.empty", AW'(busIf.o_rasEmpty), 30'h1);

    for (int i = 0; i < 3; i++) applyStimulus("stall", OP_JUMP, 26'h0_0ABC, 30'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall.pc", busIf.o_pc, 30'h0000_0C14);
    checkOutput("stall.empty", AW'(busIf.o_rasEmpty), 30'h1);
    busIf.i_npcOp = OP_RET;
    #1;
    checkOutput("stallRet.under", AW'(busIf.o_rasUnder), 30'h1);
    applyStimulus("stallRet", OP_RET, 26'h0, 30'h0000_0123, 1'b0, 1'b0, 1'b0);

    applyStimulus("rsv6", 3'b110, 26'h0_0F00, 30'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus("rsv7", 3'b111, 26'h0_0F00, 30'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("rsv.pc", busIf.o_pc, 30'h0000_0C16);
    applyStimulus("jalr", OP_JR, 26'h0, 30'h0000_0200, 1'b1, 1'b0, 1'b1);
    applyStimulus("jalrRet", OP_RET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("jalrRet.pc", busIf.o_pc, 30'h0000_0C17);

    for (int i = 1; i <= 5; i++) applyStimulus("fill", OP_JUMP, 26'(i * 'h100), 30'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("fill.full", AW'(busIf.o_rasFull), 30'h1);
    applyStimulus("pop1", OP_RET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("pop1.pc", busIf.o_pc, 30'h0000_0401);
    applyStimulus("pop2", OP_RET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("pop2.pc", busIf.o_pc, 30'h0000_0301);
    applyStimulus("pop3", OP_RET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("pop3.pc", busIf.o_pc, 30'h0000_0201);
    applyStimulus("pop4", OP_RET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("pop4.pc", busIf.o_pc, 30'h0000_0101);
    applyStimulus("pop5", OP_RET, 26'h0, 30'h0000_0C05, 1'b0, 1'b0, 1'b1);
    checkOutput("pop5.pc", busIf.o_pc, 30'h0000_0C05);

    applyStimulus("exc", OP_RET, 26'h0, 30'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("exc.pc",  busIf.o_pc,  30'h0000_1060);
    checkOutput("exc.epc", busIf.o_epc, 30'h0000_0C05);
    applyStimulus("eret", OP_ERET, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("eret.pc", busIf.o_pc, 30'h0000_0C05);

    applyStimulus("preRst", OP_JUMP, 26'h000_0777, 30'h0, 1'b1, 1'b0, 1'b1);
    doReset("midReset");
    checkOutput("midRst.pc",    busIf.o_pc,            30'h0000_0C00);
    checkOutput("midRst.empty", AW'(busIf.o_rasEmpty), 30'h1);

    applyStimulus("jTop", OP_JUMP, 26'h3FF_FFFF, 30'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus("carry", OP_PLUS4, 26'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("carry.pc", busIf.o_pc, 30'h0400_0000);
    applyStimulus("jRegion", OP_JUMP, 26'h000_0010, 30'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("jRegion.pc", busIf.o_pc, 30'h0400_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
